// File: rtl/mem_net_pkg.sv
// MemNet request/response payloads shared by the arbiter and the memory server.
package mem_net_pkg;

  localparam int unsigned OPAQ_BITS   = 8;
  localparam int unsigned ORIGIN_BITS = 2;
  localparam int unsigned ADDR_BITS   = 32;
  localparam int unsigned STRB_BITS   = 4;
  localparam int unsigned DATA_BITS   = 32;

  typedef enum logic {
    MEM_MSG_READ  = 1'b0,
    MEM_MSG_WRITE = 1'b1
  } t_op;

  typedef struct packed {
    t_op                    op;
    logic [OPAQ_BITS-1:0]   opaque;
    logic [ORIGIN_BITS-1:0] origin;
    logic [ADDR_BITS-1:0]   addr;
    logic [STRB_BITS-1:0]   strb;
    logic [DATA_BITS-1:0]   data;
  } mem_req_t;

  typedef struct packed {
    t_op                    op;
    logic [OPAQ_BITS-1:0]   opaque;
    logic [ORIGIN_BITS-1:0] origin;
    logic [ADDR_BITS-1:0]   addr;
    logic [STRB_BITS-1:0]   strb;
    logic [DATA_BITS-1:0]   data;
  } mem_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above i_ptr.
module rr_arbiter #(
  parameter int unsigned p_num_reqs = 4,
  parameter int unsigned PTR_W      = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1
) (
  input  logic [p_num_reqs-1:0] i_req,
  input  logic [PTR_W-1:0]      i_ptr,
  output logic [p_num_reqs-1:0] o_grant
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      w_idx = PTR_W'((32'(i_ptr) + k) % p_num_reqs);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_net_arb.sv
// Merges up to four client MemNet request streams into one memory channel with an
// in-flight cap, and routes memory responses back by their origin field.
module mem_net_arb
  import mem_net_pkg::*;
#(
  parameter int unsigned p_num_cli      = 4,
  parameter int unsigned p_opaq_bits    = 8,
  parameter int unsigned p_max_inflight = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [p_num_cli-1:0] i_cli_req_val,
  output logic [p_num_cli-1:0] o_cli_req_rdy,
  input  mem_req_t             i_cli_req_msg [p_num_cli],
  output logic                 o_mem_req_val,
  input  logic                 i_mem_req_rdy,
  output mem_req_t             o_mem_req_msg,
  input  logic                 i_mem_resp_val,
  output logic                 o_mem_resp_rdy,
  input  mem_resp_t            i_mem_resp_msg,
  output logic [p_num_cli-1:0] o_cli_resp_val,
  input  logic [p_num_cli-1:0] i_cli_resp_rdy,
  output mem_resp_t            o_cli_resp_msg [p_num_cli],
  output logic                 o_bad_origin
);

  localparam int unsigned PTR_W = (p_num_cli > 1) ? $clog2(p_num_cli) : 1;
  localparam int unsigned CNT_W = $clog2(p_max_inflight + 1);

  if (p_num_cli == 0 || p_num_cli > 4 || p_opaq_bits != OPAQ_BITS || p_max_inflight == 0)
  begin : g_param_err
    $error("mem_net_arb: unsupported parameter combination");
  end

  logic                 r_out_val;
  mem_req_t             r_out_msg;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]     r_inflight;
  logic                 r_bad_origin;

  logic                 w_accept;
  logic                 w_can_issue;
  logic                 w_drain;
  logic                 w_req_xfer;
  logic                 w_resp_xfer;
  logic                 w_origin_ok;
  logic [p_num_cli-1:0] w_grant;
  mem_req_t             w_sel_msg;
  logic [PTR_W-1:0]     w_next_ptr;

  rr_arbiter #(
    .p_num_reqs (p_num_cli),
    .PTR_W      (PTR_W)
  ) u_rr_arbiter (
    .i_req   (i_cli_req_val),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant)
  );

  // Output slot refills in the same cycle it drains, so the stream has no bubbles.
  assign w_drain       = r_out_val & i_mem_req_rdy;
  assign w_accept      = ~r_out_val | w_drain;
  assign w_can_issue   = w_accept & (r_inflight < CNT_W'(p_max_inflight));
  assign o_cli_req_rdy = w_grant & {p_num_cli{w_can_issue}};
  assign w_req_xfer    = |o_cli_req_rdy;

  always_comb begin
    w_sel_msg  = '0;
    w_next_ptr = r_rr_ptr;
    for (int unsigned i = 0; i < p_num_cli; i++) begin
      if (w_grant[i]) begin
        w_sel_msg        = i_cli_req_msg[i];
        w_sel_msg.origin = ORIGIN_BITS'(i);
        w_next_ptr       = PTR_W'((i + 1) % p_num_cli);
      end
    end
  end

  // Out-of-range origins are accepted unconditionally and dropped.
  always_comb begin
    o_mem_resp_rdy = 1'b1;
    o_cli_resp_val = '0;
    w_origin_ok    = 1'b0;
    for (int unsigned i = 0; i < p_num_cli; i++) begin
      o_cli_resp_msg[i] = i_mem_resp_msg;
      if (i_mem_resp_msg.origin == ORIGIN_BITS'(i)) begin
        w_origin_ok       = 1'b1;
        o_mem_resp_rdy    = i_cli_resp_rdy[i];
        o_cli_resp_val[i] = i_mem_resp_val;
      end
    end
  end

  assign w_resp_xfer = i_mem_resp_val & o_mem_resp_rdy;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_out_val    <= 1'b0;
      r_out_msg    <= '0;
      r_rr_ptr     <= '0;
      r_inflight   <= '0;
      r_bad_origin <= 1'b0;
    end else begin
      if (w_req_xfer) begin
        r_out_val <= 1'b1;
        r_out_msg <= w_sel_msg;
        r_rr_ptr  <= w_next_ptr;
      end else if (w_drain) begin
        r_out_val <= 1'b0;
      end
      // A response with nothing outstanding is a protocol error; the count stays at zero.
      if (w_req_xfer && !w_resp_xfer) begin
        r_inflight <= r_inflight + CNT_W'(1);
      end else if (!w_req_xfer && w_resp_xfer && (r_inflight != '0)) begin
        r_inflight <= r_inflight - CNT_W'(1);
      end
      if (w_resp_xfer && !w_origin_ok) begin
        r_bad_origin <= 1'b1;
      end
    end
  end

  assign o_mem_req_val = r_out_val;
  assign o_mem_req_msg = r_out_msg;
  assign o_bad_origin  = r_bad_origin;

endmodule

// File: tb/tb_mem_net_arb.sv
// Scoreboard bench for mem_net_arb: a 4-client instance under directed and random
// traffic, plus a 2-client / 2-in-flight instance for cap and bad-origin cases.
module tb_mem_net_arb;
  import mem_net_pkg::*;

  localparam int unsigned NC    = 4;
  localparam int unsigned MAXI  = 8;
  localparam int unsigned NC2   = 2;
  localparam int unsigned MAXI2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0] cli_req_val, cli_req_rdy, cli_resp_val, cli_resp_rdy;
  mem_req_t      cli_req_msg [NC];
  mem_resp_t     cli_resp_msg [NC];
  logic          mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy, bad_origin;
  mem_req_t      mem_req_msg;
  mem_resp_t     mem_resp_msg;

  logic [NC2-1:0] d2_req_val, d2_req_rdy, d2_resp_val, d2_cli_resp_rdy;
  mem_req_t       d2_req_msg [NC2];
  mem_resp_t      d2_cli_resp_msg [NC2];
  logic           d2_mem_req_val, d2_mem_req_rdy, d2_mem_resp_val, d2_mem_resp_rdy, d2_bad;
  mem_req_t       d2_mem_req_msg;
  mem_resp_t      d2_mem_resp_msg;

  mem_net_arb #(.p_num_cli(NC), .p_opaq_bits(8), .p_max_inflight(MAXI)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cli_req_val(cli_req_val), .o_cli_req_rdy(cli_req_rdy), .i_cli_req_msg(cli_req_msg),
    .o_mem_req_val(mem_req_val), .i_mem_req_rdy(mem_req_rdy), .o_mem_req_msg(mem_req_msg),
    .i_mem_resp_val(mem_resp_val), .o_mem_resp_rdy(mem_resp_rdy), .i_mem_resp_msg(mem_resp_msg),
    .o_cli_resp_val(cli_resp_val), .i_cli_resp_rdy(cli_resp_rdy), .o_cli_resp_msg(cli_resp_msg),
    .o_bad_origin(bad_origin)
  );

  mem_net_arb #(.p_num_cli(NC2), .p_opaq_bits(8), .p_max_inflight(MAXI2)) u_dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_cli_req_val(d2_req_val), .o_cli_req_rdy(d2_req_rdy), .i_cli_req_msg(d2_req_msg),
    .o_mem_req_val(d2_mem_req_val), .i_mem_req_rdy(d2_mem_req_rdy), .o_mem_req_msg(d2_mem_req_msg),
    .i_mem_resp_val(d2_mem_resp_val), .o_mem_resp_rdy(d2_mem_resp_rdy), .i_mem_resp_msg(d2_mem_resp_msg),
    .o_cli_resp_val(d2_resp_val), .i_cli_resp_rdy(d2_cli_resp_rdy), .o_cli_resp_msg(d2_cli_resp_msg),
    .o_bad_origin(d2_bad)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state of the output slot, arbitration pointer and outstanding count.
  bit       m_out_val;
  mem_req_t m_out_msg;
  int       m_ptr, m_infl;
  bit       m_resp_x;
  mem_req_t exp_q [$];
  logic [1:0] mem_q [$];

  function automatic mem_req_t rand_req();
    mem_req_t r;
    r.op     = t_op'($urandom_range(0, 1));
    r.opaque = 8'($urandom);
    r.origin = 2'($urandom);
    r.addr   = $urandom;
    r.strb   = 4'($urandom);
    r.data   = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_out_val = 1'b0;
    m_out_msg = '0;
    m_ptr     = 0;
    m_infl    = 0;
    exp_q.delete();
    mem_q.delete();
  endtask

  task automatic present_resp();
    mem_resp_t r;
    r        = mem_resp_t'(rand_req());
    r.origin = mem_q.pop_front();
    mem_resp_msg = r;
    mem_resp_val = 1'b1;
  endtask

  // One cycle: called at posedge+2 with inputs set; checks combinational outputs, advances model.
  task automatic step();
    int g, c;
    bit acc, can, rq_x, rs_x, drain;
    logic [NC-1:0] exp_rdy, exp_rval;
    logic [1:0] o;
    mem_req_t gm;
    #1;
    check("mem_req_val", 128'(mem_req_val), 128'(m_out_val));
    if (m_out_val) check("mem_req_msg_held", 128'(mem_req_msg), 128'(m_out_msg));
    acc = !m_out_val || mem_req_rdy;
    can = acc && (m_infl < int'(MAXI));
    g = -1;
    for (int k = 0; k < int'(NC); k++) begin
      c = (m_ptr + k) % int'(NC);
      if (g < 0 && cli_req_val[2'(c)]) g = c;
    end
    exp_rdy = '0;
    if (can && g >= 0) exp_rdy[2'(g)] = 1'b1;
    check("cli_req_rdy", 128'(cli_req_rdy), 128'(exp_rdy));
    o = mem_resp_msg.origin;
    exp_rval = '0;
    if (mem_resp_val) exp_rval[o] = 1'b1;
    check("cli_resp_val", 128'(cli_resp_val), 128'(exp_rval));
    check("mem_resp_rdy", 128'(mem_resp_rdy), 128'(cli_resp_rdy[o]));
    if (mem_resp_val) check("cli_resp_msg", 128'(cli_resp_msg[o]), 128'(mem_resp_msg));
    rq_x  = can && g >= 0;
    rs_x  = mem_resp_val && cli_resp_rdy[o];
    drain = m_out_val && mem_req_rdy;
    if (drain) mem_q.push_back(m_out_msg.origin);
    if (rq_x) begin
      gm        = cli_req_msg[2'(g)];
      gm.origin = 2'(g);
      exp_q.push_back(gm);
      m_out_msg = gm;
      m_out_val = 1'b1;
      m_ptr     = (g + 1) % int'(NC);
    end else if (drain) begin
      m_out_val = 1'b0;
    end
    m_infl = m_infl + int'(rq_x) - int'(rs_x);
    if (m_infl < 0) m_infl = 0;
    m_resp_x = rs_x;
    @(posedge clk);
    #2;
  endtask

  task automatic rand_msgs();
    for (int i = 0; i < int'(NC); i++) cli_req_msg[i] = rand_req();
  endtask

  // Monitor: every memory-side request transfer must match the next expected request.
  mem_req_t mon_e;
  always @(negedge clk) begin
    if (rst && mem_req_val && mem_req_rdy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mem_req_unexpected: got %0h expected no request", mem_req_msg);
      end else begin
        mon_e = exp_q.pop_front();
        check("mem_req_msg", 128'(mem_req_msg), 128'(mon_e));
      end
    end
  end

  initial begin
    cli_req_val  = '0;
    cli_resp_rdy = '1;
    mem_req_rdy  = 1'b1;
    mem_resp_val = 1'b0;
    mem_resp_msg = '0;
    for (int i = 0; i < int'(NC); i++) cli_req_msg[i] = '0;
    d2_req_val      = '0;
    d2_mem_req_rdy  = 1'b1;
    d2_mem_resp_val = 1'b0;
    d2_mem_resp_msg = '0;
    d2_cli_resp_rdy = '1;
    for (int i = 0; i < int'(NC2); i++) d2_req_msg[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    check("reset_mem_req_val", 128'(mem_req_val), 128'(0));
    check("reset_bad_origin", 128'(bad_origin), 128'(0));
    check("reset_d2_mem_req_val", 128'(d2_mem_req_val), 128'(0));

    // All clients request every cycle: grants rotate 0,1,2,3,0,1 with no bubble.
    cli_req_val = '1;
    repeat (6) begin rand_msgs(); step(); end

    // Asynchronous reset with a request held in the output slot.
    rst = 1'b0;
    #1;
    check("async_reset_mem_req_val", 128'(mem_req_val), 128'(0));
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;

    // No responses: exactly MAXI requests issue after reset, then ready stays low.
    repeat (12) begin rand_msgs(); step(); end

    // Responses free slots; a response concurrent with a request keeps the count.
    present_resp(); step(); if (m_resp_x) mem_resp_val = 1'b0;
    present_resp(); rand_msgs(); step(); if (m_resp_x) mem_resp_val = 1'b0;
    repeat (3) begin rand_msgs(); step(); end

    // Random traffic with an in-order memory model.
    repeat (1500) begin
      cli_req_val  = 4'($urandom);
      rand_msgs();
      mem_req_rdy  = ($urandom_range(0, 3) != 0);
      cli_resp_rdy = 4'($urandom);
      if (!mem_resp_val && mem_q.size() > 0 && $urandom_range(0, 1) == 1) present_resp();
      step();
      if (m_resp_x) mem_resp_val = 1'b0;
    end

    // Drain everything outstanding (bounded).
    cli_req_val  = '0;
    mem_req_rdy  = 1'b1;
    cli_resp_rdy = '1;
    for (int n = 0; n < 100; n++) begin
      if (!mem_resp_val && mem_q.size() > 0) present_resp();
      step();
      if (m_resp_x) mem_resp_val = 1'b0;
      if (mem_q.size() == 0 && !m_out_val && !mem_resp_val) break;
    end
    check("drain_done", 128'(mem_q.size() == 0 && !m_out_val && !mem_resp_val), 128'(1));

    // Back-pressure: client 2 transfers, memory stalls 5 cycles, then one transfer.
    cli_req_val = 4'b0100;
    rand_msgs();
    step();
    cli_req_val = '1;
    mem_req_rdy = 1'b0;
    repeat (5) begin rand_msgs(); step(); end
    mem_req_rdy = 1'b1;
    step();
    cli_req_val = '0;
    step();

    // Response to client 2 blocked for 3 cycles by its ready.
    present_resp();
    cli_resp_rdy = 4'b1011;
    repeat (3) step();
    cli_resp_rdy = '1;
    step();
    if (m_resp_x) mem_resp_val = 1'b0;
    present_resp();
    step();
    if (m_resp_x) mem_resp_val = 1'b0;
    step();

    // Two-client instance, cap of two: grants 0 then 1, then nothing.
    d2_req_msg[0] = rand_req();
    d2_req_msg[1] = rand_req();
    d2_req_val    = 2'b11;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      check("d2_cli_req_rdy", 128'(d2_req_rdy),
            128'((cyc == 0) ? 2'b01 : (cyc == 1) ? 2'b10 : 2'b00));
      if (cyc == 1) check("d2_origin0", 128'({d2_mem_req_val, d2_mem_req_msg.origin}), 128'(3'b100));
      if (cyc == 2) check("d2_origin1", 128'({d2_mem_req_val, d2_mem_req_msg.origin}), 128'(3'b101));
      if (cyc == 3) check("d2_drained", 128'(d2_mem_req_val), 128'(0));
      @(posedge clk);
      #2;
    end

    // Origin 3 is out of range for two clients: dropped, flagged, still frees a slot.
    d2_req_val      = '0;
    d2_cli_resp_rdy = '0;
    d2_mem_resp_msg = mem_resp_t'(rand_req());
    d2_mem_resp_msg.origin = 2'd3;
    d2_mem_resp_val = 1'b1;
    #1;
    check("d2_bad_resp_rdy", 128'(d2_mem_resp_rdy), 128'(1));
    check("d2_bad_resp_val", 128'(d2_resp_val), 128'(0));
    check("d2_bad_before", 128'(d2_bad), 128'(0));
    @(posedge clk);
    #2;
    d2_mem_resp_val = 1'b0;
    d2_req_val      = 2'b01;
    #1;
    check("d2_bad_after", 128'(d2_bad), 128'(1));
    check("d2_slot_freed", 128'(d2_req_rdy), 128'(2'b01));
    @(posedge clk);
    #3;
    check("d2_cap_again", 128'(d2_req_rdy), 128'(2'b00));
    check("d2_bad_sticky", 128'(d2_bad), 128'(1));
    d2_req_val = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
